// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate with weight fetch, bias add and saturation
module neuron_mac #(
    parameter int numWeight = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [dataWidth-1:0]      myinput,
    input  logic                      myinputValid,
    input  logic [2*dataWidth-1:0]    bias,
    output logic                      ren,
    output logic [addressWidth-1:0]   radd,
    input  logic [dataWidth-1:0]      wout,
    output logic [2*dataWidth-1:0]    out,
    output logic                      outvalid
);
    localparam int W = 2*dataWidth;
    function automatic logic [W-1:0] sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
        return (a[W-1] == b[W-1] && s[W-1] != a[W-1]) ? {a[W-1], {(W-1){~a[W-1]}}} : s;
    endfunction
    logic [addressWidth-1:0] rcount;
    logic [dataWidth-1:0]    x_d;
    logic signed [W-1:0]     prod;
    logic [W-1:0]            mul, sum;
    logic                    v1, v2, last1, last2, last3, at_end;
    assign ren = myinputValid;
    assign radd = rcount;
    assign at_end = rcount == addressWidth'(numWeight-1);
    assign prod = $signed(x_d) * $signed(wout);
    always_ff @(posedge clk) begin
        if (rst) begin
            rcount <= '0;
            x_d <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
            last3 <= 1'b0;
            mul <= '0;
            sum <= '0;
            out <= '0;
            outvalid <= 1'b0;
        end else begin
            if (myinputValid) rcount <= at_end ? '0 : rcount + 1'b1;
            x_d <= myinput;
            v1 <= myinputValid;
            last1 <= myinputValid && at_end;
            mul <= prod;
            v2 <= v1;
            last2 <= last1;
            last3 <= last2 & v2;
            // a product landing on the final-sum edge opens the next vector
            sum <= last3 ? (v2 ? mul : '0) : (v2 ? sat(sum, mul) : sum);
            outvalid <= last3;
            if (last3) out <= sat(sum, bias);
        end
    end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Compute datapath for one neuron, directly downstream of the per-neuron weight memory.
- Consumes a stream of numWeight signed activations and issues one read per activation to the weight memory, whose read data returns one cycle after the request.
- Multiply-accumulates activation × weight, adds the neuron bias, and presents one saturated pre-activation sum per input vector to the activation stage.

Parameters:
- numWeight, 3: activations (and weights) per input vector; must be ≥1.
- addressWidth, 10: weight read address width; 2^addressWidth ≥ numWeight.
- dataWidth, 16: signed activation/weight width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- myinput  in  dataWidth  signed activation.
- myinputValid  in  1  myinput valid this cycle; no backpressure.
- bias  in  2*dataWidth  signed bias; sampled only on the final-sum cycle.
- ren  out  1  weight-memory read enable.
- radd  out  addressWidth  weight-memory read address.
- wout  in  dataWidth  weight-memory read data; valid the cycle after ren.
- out  out  2*dataWidth  signed saturated sum + bias.
- outvalid  out  1  one-cycle pulse marking out valid.

Behaviour:
- ren = myinputValid (combinational); radd = rcount (registered address counter).
- rcount: reset 0; on each accepted input, rcount <= (rcount == numWeight-1) ? 0 : rcount+1. Wraps per vector.
- Edge 1 (after input cycle): x_d <= myinput; v1 <= myinputValid; last1 <= (accepted and rcount == numWeight-1). wout is aligned with x_d in the following cycle.
- Edge 2: mul <= signed(x_d) × signed(wout), full 2*dataWidth; v2 <= v1; last2 <= last1.
- Edge 3: if v2, sum <= sat(sum + mul); last3 <= last2 & v2.
- Edge 4, when last3 = 1:
  - out <= sat(sum + bias); outvalid <= 1.
  - sum <= (v2 ? sat(0 + mul) : 0). The first product of a back-to-back next vector is preserved, never dropped and never merged into the previous vector.
- Otherwise outvalid <= 0; out holds its last value.
- sat(a+b): signed 2*dataWidth add. If a and b have the same sign and the result sign differs, clamp to 0x7F..F (positive) or 0x80..0 (negative).
- Latency: final input in cycle t → outvalid high in cycle t+4 for exactly one cycle.
- Gaps (myinputValid = 0) are allowed anywhere in a vector. No state advances on an idle cycle except pipeline drain.
- Back-to-back vectors are supported at full rate: one activation per cycle, no bubbles.
- Reset value of every register is 0: rcount, x_d, v1/v2, last1–3, mul, sum, out, outvalid.
- ren is 0 during reset only if myinputValid is 0. The upstream stage holds myinputValid low during reset.
- rst mid-vector discards all partial state: no outvalid for that vector. The next accepted input is element 0, address 0.
- Overflow does not wrap at any stage. Once clamped, sum continues accumulating from the clamped value.

Test Plan:
- dataWidth=16, numWeight=3, weights {2,3,-1}, inputs 4,5,6 on consecutive cycles, bias=10:
  - radd = 0,1,2 with ren high for 3 cycles.
  - outvalid pulses 4 cycles after input 6.
  - out = 27.
- Same vector with one idle cycle between inputs 5 and 6 → out = 27; outvalid 4 cycles after input 6; radd unchanged during the gap.
- Two vectors back-to-back over 6 consecutive cycles, second vector 1,1,1, bias=10:
  - First out = 27; second out = 2+3-1+10 = 14.
  - outvalid pulses exactly 3 cycles apart; radd wraps 2→0.
- Weights and inputs all 0x7FFF, bias=0 → each product 0x3FFF0001; out = 0x7FFFFFFF (saturated). Weights all 0x8000 with inputs 0x7FFF → out = 0x80000000.
- rst asserted for 1 cycle after input 5 of the first vector, then vector 4,5,6 fed fresh:
  - No outvalid for the aborted vector.
  - radd restarts at 0.
  - out = 27.
- Reset check: while rst is held, out = 0, outvalid = 0, and radd = 0 every cycle.
